multi_cycle_control: RTL and testbench
======================================

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003: opcode_i  input  7  opcode field of the instruction register (instr[6:0]); valid from DECODE onward.
REQ-004: mem_ready_i  input  1  memory completion strobe; completes the current mem_read_o/mem_write_o request in the cycle it is high.
REQ-005: pc_write_o  output  1  PC register load enable.
REQ-006: ir_write_o  output  1  instruction register load enable.
REQ-007: mem_read_o  output  1  memory read request.
REQ-008: mem_write_o  output  1  memory write request.
REQ-009: reg_write_o  output  1  register file write enable.
REQ-010: result_src_o  output  2  write-back select: 00 ALU result, 01 memory data, 10 PC+4.
REQ-011: alu_op_o  output  3  ALU_Op class sent to the ALU control decoder.
  - 000 R, 001 I-arith, 010 LUI, 011 branch, 100 store, 101 load, 110 JAL, 111 JALR.
REQ-012: branch_o  output  1  branch-evaluate strobe.
REQ-013: illegal_o  output  1  sticky unsupported-opcode flag.
REQ-014: state_o  output  4  current state encoding.
REQ-015: retire_count_o  output  32  count of retired instructions.

Function
REQ-016: The block SHALL be a Moore FSM; all outputs SHALL be decoded from the registered state and latched opcode only, and SHALL NOT combinationally depend on mem_ready_i.
REQ-017: State encodings SHALL be: FETCH=0, DECODE=1, EXEC=2, MEMADR=3, MEMRD=4, MEMWR=5, WB_ALU=6, WB_MEM=7, BRANCH=8, JUMP=9, TRAP=10.
REQ-018: All outputs SHALL be 0 in any state except where this section asserts them.
REQ-019: FETCH SHALL assert mem_read_o and hold it.
  - mem_ready_i=0: remain in FETCH.
  - mem_ready_i=1: go to DECODE; pc_write_o and ir_write_o SHALL pulse high for exactly one cycle, the first cycle of DECODE.
REQ-020: On entry to DECODE, the block SHALL latch opcode_i. From DECODE:
  - 0110011, 0010011, 0110111 -> EXEC.
  - 0000011, 0100011 -> MEMADR.
  - 1100011 -> BRANCH.
  - 1101111, 1100111 -> JUMP.
  - any other opcode -> TRAP.
REQ-021: EXEC SHALL drive alu_op_o 000, 001 or 010 for R, I-arith or LUI respectively, then go to WB_ALU.
REQ-022: WB_ALU SHALL assert reg_write_o with result_src_o=00 for one cycle, then go to FETCH.
REQ-023: MEMADR SHALL drive alu_op_o=101 for a load or 100 for a store, then go to MEMRD (load) or MEMWR (store).
REQ-024: MEMRD SHALL hold mem_read_o high until mem_ready_i=1, then go to WB_MEM.
REQ-025: MEMWR SHALL hold mem_write_o high until mem_ready_i=1, then go to FETCH.
REQ-026: WB_MEM SHALL assert reg_write_o with result_src_o=01 for one cycle, then go to FETCH.
REQ-027: BRANCH SHALL assert branch_o with alu_op_o=011 for one cycle, then go to FETCH.
REQ-028: JUMP SHALL, for one cycle, assert pc_write_o and reg_write_o with result_src_o=10 and alu_op_o=110 (JAL) or 111 (JALR), then go to FETCH.
REQ-029: TRAP SHALL assert illegal_o, issue no memory or register writes, and remain in TRAP until reset.
REQ-030: mem_read_o and mem_write_o SHALL never be high in the same cycle, and each SHALL deassert in the cycle after mem_ready_i is sampled high.
REQ-031: mem_ready_i SHALL be ignored in every state other than FETCH, MEMRD and MEMWR.
REQ-032: retire_count_o SHALL increment by 1 on every transition into FETCH from WB_ALU, WB_MEM, MEMWR, BRANCH or JUMP.
  - It SHALL wrap from 0xFFFFFFFF to 0.
  - It SHALL NOT increment on the transition out of reset.
REQ-033: Instruction latency in cycles, counting each FETCH/MEMRD/MEMWR as 1 wait-free cycle:
  - R/I/LUI 4, load 5, store 4, branch 3, jump 3.
  - Each extra cycle with mem_ready_i low adds 1.

Reset
REQ-034: reset=1 SHALL, at the next rising edge regardless of state, force state FETCH, clear retire_count_o to 0, clear illegal_o and the latched opcode, and drive all control outputs to 0 except mem_read_o, which reflects FETCH.
REQ-035: Reset asserted mid-request SHALL abandon the outstanding memory request without completing any register or PC write.

Verification
REQ-036: Reset, then opcode 0110011 with mem_ready_i always 1 -> states 0,1,2,6,0; alu_op_o=000 in EXEC; reg_write_o=1 only in WB_ALU; retire_count_o=1.
REQ-037: Load 0000011, mem_ready_i low for 3 cycles in MEMRD -> MEMRD lasts 4 cycles with mem_read_o high; WB_MEM result_src_o=01; total 8 cycles.
REQ-038: Opcode 1111111 -> DECODE->TRAP; illegal_o=1 held for 20 cycles; retire_count_o unchanged; reset returns the block to FETCH with illegal_o=0.
REQ-039: Preload retire_count_o to 0xFFFFFFFF via 2^32-1 forced retirements (or a bench force), then one BRANCH -> retire_count_o=0; branch_o high exactly 1 cycle.
REQ-040: Reset asserted while in MEMWR with mem_write_o=1 -> next cycle state_o=0, mem_write_o=0, reg_write_o=0, pc_write_o=0.
REQ-041: JALR 1100111 -> JUMP cycle has pc_write_o=1, reg_write_o=1, result_src_o=10, alu_op_o=111; back-to-back JAL then store retire in 3+4 cycles.

Source files
------------

// File: rtl/multi_cycle_control_if.sv
// Control-unit boundary: instruction/memory status in, datapath control strobes out.
// The master side is the control FSM; the slave side is the datapath or bench.
interface multi_cycle_control_if;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 32;

  logic [OPC_W-1:0] opcode_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ir_write_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             reg_write_o;
  logic [1:0]       result_src_o;
  logic [2:0]       alu_op_o;
  logic             branch_o;
  logic             illegal_o;
  logic [ST_W-1:0]  state_o;
  logic [CNT_W-1:0] retire_count_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
           result_src_o, alu_op_o, branch_o, illegal_o, state_o, retire_count_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, ir_write_o, mem_read_o, mem_write_o, reg_write_o,
           result_src_o, alu_op_o, branch_o, illegal_o, state_o, retire_count_o
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle RV32 subset core: sequences fetch, decode,
// execute, memory and write-back, and counts retired instructions.
module multi_cycle_control (
  input  logic                  clk,
  input  logic                  reset,
  multi_cycle_control_if.master bus
);
  localparam int unsigned OPC_W = 7;
  localparam int unsigned CNT_W = 32;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] ALU_R     = 3'b000;
  localparam logic [2:0] ALU_I     = 3'b001;
  localparam logic [2:0] ALU_LUI   = 3'b010;
  localparam logic [2:0] ALU_BR    = 3'b011;
  localparam logic [2:0] ALU_STORE = 3'b100;
  localparam logic [2:0] ALU_LOAD  = 3'b101;
  localparam logic [2:0] ALU_JAL   = 3'b110;
  localparam logic [2:0] ALU_JALR  = 3'b111;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_WB_ALU = 4'd6,
    S_WB_MEM = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_TRAP   = 4'd10
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [OPC_W-1:0]   r_opcode;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_retire;
  logic               w_retire;

  logic       w_pc_write;
  logic       w_ir_write;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [2:0] w_alu_op;
  logic       w_branch;

  // An instruction retires whenever a terminal state hands control back to FETCH.
  always_comb begin
    w_retire = 1'b0;
    if (w_next == S_FETCH) begin
      case (r_state)
        S_WB_ALU, S_WB_MEM, S_MEMWR, S_BRANCH, S_JUMP: w_retire = 1'b1;
        default:                                       w_retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_opcode  <= '0;
      r_illegal <= 1'b0;
      r_retire  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode <= bus.opcode_i;
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire) r_retire <= r_retire + CNT_W'(1);
    end
  end

  // Next-state and Moore output decode; mem_ready_i only steers the three wait states.
  always_comb begin
    w_next       = r_state;
    w_pc_write   = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = RES_ALU;
    w_alu_op     = ALU_R;
    w_branch     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready_i) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_pc_write = 1'b1;
        w_ir_write = 1'b1;
        case (bus.opcode_i)
          OP_R, OP_I, OP_LUI:  w_next = S_EXEC;
          OP_LOAD, OP_STORE:   w_next = S_MEMADR;
          OP_BRANCH:           w_next = S_BRANCH;
          OP_JAL, OP_JALR:     w_next = S_JUMP;
          default:             w_next = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (r_opcode)
          OP_I:    w_alu_op = ALU_I;
          OP_LUI:  w_alu_op = ALU_LUI;
          default: w_alu_op = ALU_R;
        endcase
        w_next = S_WB_ALU;
      end
      S_MEMADR: begin
        if (r_opcode == OP_STORE) begin
          w_alu_op = ALU_STORE;
          w_next   = S_MEMWR;
        end else begin
          w_alu_op = ALU_LOAD;
          w_next   = S_MEMRD;
        end
      end
      S_MEMRD: begin
        w_mem_read = 1'b1;
        if (bus.mem_ready_i) w_next = S_WB_MEM;
      end
      S_MEMWR: begin
        w_mem_write = 1'b1;
        if (bus.mem_ready_i) w_next = S_FETCH;
      end
      S_WB_ALU: begin
        w_reg_write  = 1'b1;
        w_result_src = RES_ALU;
        w_next       = S_FETCH;
      end
      S_WB_MEM: begin
        w_reg_write  = 1'b1;
        w_result_src = RES_MEM;
        w_next       = S_FETCH;
      end
      S_BRANCH: begin
        w_branch = 1'b1;
        w_alu_op = ALU_BR;
        w_next   = S_FETCH;
      end
      S_JUMP: begin
        w_pc_write   = 1'b1;
        w_reg_write  = 1'b1;
        w_result_src = RES_PC4;
        w_alu_op     = (r_opcode == OP_JALR) ? ALU_JALR : ALU_JAL;
        w_next       = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.pc_write_o     = w_pc_write;
  assign bus.ir_write_o     = w_ir_write;
  assign bus.mem_read_o     = w_mem_read;
  assign bus.mem_write_o    = w_mem_write;
  assign bus.reg_write_o    = w_reg_write;
  assign bus.result_src_o   = w_result_src;
  assign bus.alu_op_o       = w_alu_op;
  assign bus.branch_o       = w_branch;
  assign bus.illegal_o      = r_illegal;
  assign bus.state_o        = r_state;
  assign bus.retire_count_o = r_retire;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed vector table, corner-case
// sequences, and randomized instruction streams against a phase-list model.
module tb_multi_cycle_control;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multi_cycle_control_if bus();
  multi_cycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  int plan[$];

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    int          st;
    logic [11:0] ctl;
    logic [31:0] ret;
  } vec_t;
  vec_t vt[20];

  // ctl bits: pc_write, ir_write, mem_read, mem_write, reg_write, result_src[1:0], alu_op[2:0], branch, illegal
  function automatic logic [11:0] mk(logic pcw, logic irw, logic mr, logic mw, logic rw,
                                     logic [1:0] rs, logic [2:0] alu, logic br, logic ill);
    return {pcw, irw, mr, mw, rw, rs, alu, br, ill};
  endfunction

  function automatic logic [11:0] ctl_now();
    return {bus.pc_write_o, bus.ir_write_o, bus.mem_read_o, bus.mem_write_o, bus.reg_write_o,
            bus.result_src_o, bus.alu_op_o, bus.branch_o, bus.illegal_o};
  endfunction

  // Expected control word for a given state while executing instruction op.
  function automatic logic [11:0] exp_ctl(int st, logic [6:0] op);
    case (st)
      0:  return mk(0, 0, 1, 0, 0, 2'b00, 3'b000, 0, 0);
      1:  return mk(1, 1, 0, 0, 0, 2'b00, 3'b000, 0, 0);
      2:  return mk(0, 0, 0, 0, 0, 2'b00, (op == OP_I) ? 3'b001 : (op == OP_LUI) ? 3'b010 : 3'b000, 0, 0);
      3:  return mk(0, 0, 0, 0, 0, 2'b00, (op == OP_STORE) ? 3'b100 : 3'b101, 0, 0);
      4:  return mk(0, 0, 1, 0, 0, 2'b00, 3'b000, 0, 0);
      5:  return mk(0, 0, 0, 1, 0, 2'b00, 3'b000, 0, 0);
      6:  return mk(0, 0, 0, 0, 1, 2'b00, 3'b000, 0, 0);
      7:  return mk(0, 0, 0, 0, 1, 2'b01, 3'b000, 0, 0);
      8:  return mk(0, 0, 0, 0, 0, 2'b00, 3'b011, 1, 0);
      9:  return mk(1, 0, 0, 0, 1, 2'b10, (op == OP_JALR) ? 3'b111 : 3'b110, 0, 0);
      default: return mk(0, 0, 0, 0, 0, 2'b00, 3'b000, 0, 1);
    endcase
  endfunction

  // State sequence of one instruction (one entry per phase, waits excluded).
  task automatic build_plan(input logic [6:0] op);
    plan = {};
    plan.push_back(0);
    plan.push_back(1);
    case (op)
      OP_R, OP_I, OP_LUI: begin plan.push_back(2); plan.push_back(6); end
      OP_LOAD:            begin plan.push_back(3); plan.push_back(4); plan.push_back(7); end
      OP_STORE:           begin plan.push_back(3); plan.push_back(5); end
      OP_BRANCH:          plan.push_back(8);
      OP_JAL, OP_JALR:    plan.push_back(9);
      default:            plan.push_back(10);
    endcase
  endtask

  task automatic check(input string nm, input int est, input logic [11:0] ectl, input logic [31:0] eret);
    total++;
    if (bus.state_o !== 4'(est) || ctl_now() !== ectl || bus.retire_count_o !== eret) begin
      bad++;
      $display("FAIL %s: got state=%0d ctl=%b retire=%0d, want state=%0d ctl=%b retire=%0d",
               nm, bus.state_o, ctl_now(), bus.retire_count_o, est, ectl, eret);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [6:0] op, input logic rdy);
    reset           = rst;
    bus.opcode_i    = op;
    bus.mem_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction with memory always ready; returns cycles until FETCH again.
  task automatic run_instr(input logic [6:0] op, output int cyc);
    cyc = 0;
    do begin
      step(1'b0, op, 1'b1);
      cyc++;
    end while (bus.state_o != 4'd0 && cyc < 20);
  endtask

  initial begin
    int cyc;
    logic [31:0] cnt;
    logic [6:0] ops[8];
    logic [6:0] op;
    int w;
    logic rdy;

    reset = 1'b1;
    bus.opcode_i = '0;
    bus.mem_ready_i = 1'b0;

    vt[0]  = '{1'b1, OP_R,      1'b0, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd0};
    vt[1]  = '{1'b0, OP_R,      1'b1, 1, mk(1,1,0,0,0,2'b00,3'b000,0,0), 32'd0};
    vt[2]  = '{1'b0, OP_R,      1'b0, 2, mk(0,0,0,0,0,2'b00,3'b000,0,0), 32'd0};
    vt[3]  = '{1'b0, OP_R,      1'b1, 6, mk(0,0,0,0,1,2'b00,3'b000,0,0), 32'd0};
    vt[4]  = '{1'b0, OP_R,      1'b0, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd1};
    vt[5]  = '{1'b0, OP_I,      1'b0, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd1};
    vt[6]  = '{1'b0, OP_I,      1'b1, 1, mk(1,1,0,0,0,2'b00,3'b000,0,0), 32'd1};
    vt[7]  = '{1'b0, OP_I,      1'b0, 2, mk(0,0,0,0,0,2'b00,3'b001,0,0), 32'd1};
    vt[8]  = '{1'b0, OP_I,      1'b0, 6, mk(0,0,0,0,1,2'b00,3'b000,0,0), 32'd1};
    vt[9]  = '{1'b0, OP_JALR,   1'b0, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd2};
    vt[10] = '{1'b0, OP_JALR,   1'b1, 1, mk(1,1,0,0,0,2'b00,3'b000,0,0), 32'd2};
    vt[11] = '{1'b0, OP_JALR,   1'b1, 9, mk(1,0,0,0,1,2'b10,3'b111,0,0), 32'd2};
    vt[12] = '{1'b0, OP_JALR,   1'b0, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd3};
    vt[13] = '{1'b0, OP_BRANCH, 1'b1, 1, mk(1,1,0,0,0,2'b00,3'b000,0,0), 32'd3};
    vt[14] = '{1'b0, OP_BRANCH, 1'b0, 8, mk(0,0,0,0,0,2'b00,3'b011,1,0), 32'd3};
    vt[15] = '{1'b0, OP_BRANCH, 1'b1, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd4};
    vt[16] = '{1'b0, OP_LUI,    1'b1, 1, mk(1,1,0,0,0,2'b00,3'b000,0,0), 32'd4};
    vt[17] = '{1'b0, OP_LUI,    1'b0, 2, mk(0,0,0,0,0,2'b00,3'b010,0,0), 32'd4};
    vt[18] = '{1'b0, OP_LUI,    1'b1, 6, mk(0,0,0,0,1,2'b00,3'b000,0,0), 32'd4};
    vt[19] = '{1'b0, OP_LUI,    1'b0, 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd5};

    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      step(vt[i].rst, vt[i].op, vt[i].rdy);
      check($sformatf("vec%0d", i), vt[i].st, vt[i].ctl, vt[i].ret);
    end

    // Load with three stalled MEMRD cycles: 8 cycles total.
    begin
      logic rdy_seq[8];
      int   st_seq[8];
      rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      st_seq  = '{1, 3, 4, 4, 4, 4, 7, 0};
      for (int i = 0; i < 8; i++) begin
        step(1'b0, OP_LOAD, rdy_seq[i]);
        check($sformatf("load_stall%0d", i), st_seq[i], exp_ctl(st_seq[i], OP_LOAD),
              (i == 7) ? 32'd6 : 32'd5);
      end
    end

    // Back-to-back JAL then store: 3 + 4 cycles.
    run_instr(OP_JAL, cyc);
    check_int("jal_cycles", cyc, 3);
    check("jal_retire", 0, exp_ctl(0, OP_JAL), 32'd7);
    run_instr(OP_STORE, cyc);
    check_int("store_cycles", cyc, 4);
    check("store_retire", 0, exp_ctl(0, OP_STORE), 32'd8);

    // Reset while a store is waiting in MEMWR abandons the write.
    step(1'b0, OP_STORE, 1'b1);
    step(1'b0, OP_STORE, 1'b1);
    step(1'b0, OP_STORE, 1'b0);
    check("memwr_wait", 5, exp_ctl(5, OP_STORE), 32'd8);
    step(1'b1, OP_STORE, 1'b1);
    check("memwr_reset", 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd0);

    // Illegal opcode: sticky TRAP for 20 cycles, retire count frozen, reset recovers.
    step(1'b0, OP_BRANCH, 1'b1);
    step(1'b0, OP_BRANCH, 1'b0);
    step(1'b0, OP_BRANCH, 1'b0);
    check("pre_trap", 0, exp_ctl(0, OP_BRANCH), 32'd1);
    step(1'b0, OP_BAD, 1'b1);
    check("trap_decode", 1, exp_ctl(1, OP_BAD), 32'd1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, (i == 0) ? OP_BAD : 7'($urandom), 1'($urandom));
      check($sformatf("trap%0d", i), 10, mk(0,0,0,0,0,2'b00,3'b000,0,1), 32'd1);
    end
    step(1'b1, OP_BAD, 1'b0);
    check("trap_reset", 0, mk(0,0,1,0,0,2'b00,3'b000,0,0), 32'd0);

    // Retire counter wrap: preload all-ones, one branch wraps to zero.
    step(1'b0, OP_BRANCH, 1'b0);
    force dut.r_retire = 32'hFFFF_FFFF;
    #1;
    release dut.r_retire;
    #1;
    check("wrap_preload", 0, exp_ctl(0, OP_BRANCH), 32'hFFFF_FFFF);
    step(1'b0, OP_BRANCH, 1'b1);
    check("wrap_decode", 1, exp_ctl(1, OP_BRANCH), 32'hFFFF_FFFF);
    step(1'b0, OP_BRANCH, 1'b1);
    check("wrap_branch", 8, exp_ctl(8, OP_BRANCH), 32'hFFFF_FFFF);
    step(1'b0, OP_BRANCH, 1'b1);
    check("wrap_zero", 0, exp_ctl(0, OP_BRANCH), 32'd0);

    // Randomized instruction stream with random memory stalls and noise on ignored inputs.
    ops = '{OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
    step(1'b1, OP_R, 1'b0);
    cnt = 32'd0;
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 7)];
      build_plan(op);
      foreach (plan[p]) begin
        if (plan[p] == 0 || plan[p] == 4 || plan[p] == 5) w = int'($urandom_range(0, 3));
        else w = 0;
        for (int k = 0; k <= w; k++) begin
          check("rand", plan[p], exp_ctl(plan[p], op), cnt);
          if (plan[p] == 0 || plan[p] == 4 || plan[p] == 5) rdy = (k == w);
          else rdy = 1'($urandom);
          step(1'b0, (plan[p] == 0) ? 7'($urandom) : op, rdy);
        end
      end
      cnt = cnt + 32'd1;
    end
    check("rand_end", 0, exp_ctl(0, OP_R), cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
